// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: selects the next fetch address from
// exception, eret, redirect, call/return prediction (via a circular RAS) or sequential.
module pc_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         stall,
  input  logic                         exc_valid,
  input  logic [WIDTH-1:0]             exc_pc,
  input  logic                         eret_valid,
  input  logic                         redirect_valid,
  input  logic [WIDTH-1:0]             redirect_pc,
  input  logic                         call_valid,
  input  logic [WIDTH-1:0]             call_target,
  input  logic                         ret_valid,
  output logic [WIDTH-1:0]             currPC,
  output logic [WIDTH-1:0]             epc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_EXC,
    SEL_ERET,
    SEL_REDIR,
    SEL_CALL,
    SEL_RET,
    SEL_REPL
  } sel_t;

  sel_t             sel;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] inc_pc;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic             ras_empty;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  // Power-of-two depth lets the pointer wrap by plain overflow.
  assign inc_pc    = currPC + WIDTH'(INC);
  assign ptr_inc   = top_ptr + PTR_W'(1);
  assign ptr_dec   = top_ptr - PTR_W'(1);
  assign ras_empty = (ras_count == '0);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel = SEL_HOLD;
    if (exc_valid)           sel = SEL_EXC;
    else if (eret_valid)     sel = SEL_ERET;
    else if (redirect_valid) sel = SEL_REDIR;
    else if (!stall) begin
      if (call_valid && ret_valid && !ras_empty) sel = SEL_REPL;
      else if (call_valid)                       sel = SEL_CALL;
      else if (ret_valid && !ras_empty)          sel = SEL_RET;
      else                                       sel = SEL_SEQ;
    end
  end

  always_comb begin
    next_pc = currPC;
    unique case (sel)
      SEL_EXC:             next_pc = EXC_VECTOR;
      SEL_ERET:            next_pc = epc;
      SEL_REDIR:           next_pc = redirect_pc;
      SEL_CALL, SEL_REPL:  next_pc = call_target;
      SEL_RET:             next_pc = ras_mem[top_ptr];
      SEL_SEQ:             next_pc = inc_pc;
      default:             next_pc = currPC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      currPC    <= RESET_VECTOR;
      epc       <= '0;
      ras_count <= '0;
      top_ptr   <= '0;
    end else begin
      currPC <= next_pc;
      if (exc_valid) epc <= exc_pc;
      case (sel)
        SEL_CALL: begin
          top_ptr <= ptr_inc;
          if (ras_count != RAS_FULL) ras_count <= ras_count + CNT_W'(1);
        end
        SEL_RET: begin
          top_ptr   <= ptr_dec;
          ras_count <= ras_count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: RAS storage is not reset; ras_count gates every read, so stale contents are never used.
  always_ff @(posedge CLK) begin
    case (sel)
      SEL_CALL: ras_mem[ptr_inc] <= inc_pc;
      SEL_REPL: ras_mem[top_ptr] <= inc_pc;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed test-plan steps followed by random
// stimulus, compared against a queue-based reference model.
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stall = 1'b0;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_pc = '0;
  logic        eret_valid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        call_valid = 1'b0;
  logic [31:0] call_target = '0;
  logic        ret_valid = 1'b0;
  logic [31:0] currPC;
  logic [31:0] epc;
  logic [2:0]  ras_count;

  int passed = 0;
  int total  = 0;

  // Reference model state: RAS kept as a queue, newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_ras[$];

  pc_gen #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h0000_0080),
    .INC(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .stall(stall),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .eret_valid(eret_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .call_valid(call_valid), .call_target(call_target), .ret_valid(ret_valid),
    .currPC(currPC), .epc(epc), .ras_count(ras_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_epc = 32'h0;
    m_ras.delete();
  endtask

  task automatic model_step(input logic st, input logic ex, input logic [31:0] expc,
                            input logic er, input logic rd, input logic [31:0] rpc,
                            input logic cl, input logic [31:0] ct, input logic rt);
    if (ex) begin
      m_pc  = 32'h80;
      m_epc = expc;
    end else if (er) begin
      m_pc = m_epc;
    end else if (rd) begin
      m_pc = rpc;
    end else if (!st) begin
      if (cl && rt && m_ras.size() > 0) begin
        m_ras[m_ras.size()-1] = m_pc + 32'd4;
        m_pc = ct;
      end else if (cl) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        m_pc = ct;
      end else if (rt && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare all outputs.
  task automatic step(input string tag, input logic st, input logic ex, input logic [31:0] expc,
                      input logic er, input logic rd, input logic [31:0] rpc,
                      input logic cl, input logic [31:0] ct, input logic rt);
    stall = st; exc_valid = ex; exc_pc = expc; eret_valid = er;
    redirect_valid = rd; redirect_pc = rpc; call_valid = cl; call_target = ct; ret_valid = rt;
    @(posedge CLK);
    model_step(st, ex, expc, er, rd, rpc, cl, ct, rt);
    #1;
    check({tag, ".pc"},  currPC, m_pc);
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".cnt"}, {29'd0, ras_count}, m_ras.size());
  endtask

  task automatic seq(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input string tag, input logic [31:0] a);
    step(tag, 0, 0, 0, 0, 1, a, 0, 0, 0);
  endtask

  task automatic call(input string tag, input logic [31:0] t);
    step(tag, 0, 0, 0, 0, 0, 0, 1, t, 0);
  endtask

  task automatic ret(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    #1;
    check("reset.pc",  currPC, 32'h0);
    check("reset.epc", epc, 32'h0);
    check("reset.cnt", {29'd0, ras_count}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Free run, then asynchronous reset mid-cycle.
    seq("run1"); seq("run2"); seq("run3");
    check("run.pc12", currPC, 32'hC);
    #3;
    RST = 1'b1;
    #1;
    check("async_rst.pc", currPC, 32'h0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;

    // Stall vs redirect.
    repeat (4) seq("to10");
    check("at10", currPC, 32'h10);
    step("stall1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("stall2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("stall.hold", currPC, 32'h10);
    step("stall_redir", 1, 0, 0, 0, 1, 32'h200, 0, 0, 0);
    check("stall_redir.pc", currPC, 32'h200);

    // Exception and eret, then both together.
    redirect("to40", 32'h40);
    step("exc", 0, 1, 32'h3C, 0, 0, 0, 1, 32'h999, 0);
    check("exc.pc", currPC, 32'h80);
    check("exc.epc", epc, 32'h3C);
    seq("exc_seq");
    step("eret", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("eret.pc", currPC, 32'h3C);
    step("exc_eret", 0, 1, 32'h50, 1, 0, 0, 0, 0, 0);
    check("exc_eret.pc", currPC, 32'h80);
    check("exc_eret.epc", epc, 32'h50);

    // Basic call / return / empty return.
    redirect("to100", 32'h100);
    call("call400", 32'h400);
    check("call.pc", currPC, 32'h400);
    check("call.cnt", {29'd0, ras_count}, 32'd1);
    ret("ret1");
    check("ret.pc", currPC, 32'h104);
    ret("ret_empty");
    check("ret_empty.pc", currPC, 32'h108);

    // Overflow: five calls into a four-entry stack.
    redirect("to0", 32'h0);
    call("ov1", 32'h10); call("ov2", 32'h20); call("ov3", 32'h30);
    call("ov4", 32'h40); call("ov5", 32'h1000);
    check("ov.cnt", {29'd0, ras_count}, 32'd4);
    ret("ovr1"); check("ovr1.pc", currPC, 32'h44);
    ret("ovr2"); check("ovr2.pc", currPC, 32'h34);
    ret("ovr3"); check("ovr3.pc", currPC, 32'h24);
    ret("ovr4"); check("ovr4.pc", currPC, 32'h14);
    ret("ovr5"); check("ovr5.pc", currPC, 32'h18);

    // Address wrap, then call+return replacing the top entry.
    redirect("toFFFC", 32'hFFFF_FFFC);
    seq("wrap");
    check("wrap.pc", currPC, 32'h0);
    redirect("to4FC", 32'h4FC);
    call("push500", 32'h600);
    step("callret", 0, 0, 0, 0, 0, 0, 1, 32'h700, 1);
    check("callret.pc", currPC, 32'h700);
    check("callret.cnt", {29'd0, ras_count}, 32'd1);
    ret("callret_top");
    check("callret_top.pc", currPC, 32'h604);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(3) == 0,
           $urandom_range(15) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(15) == 0,
           $urandom_range(9) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(3) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(2) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage, successor to the single-register PC. It holds the current fetch address and selects the next one from sequential increment, a redirect target from execute, an exception vector, an exception return, or a predicted return from an internal return-address stack (RAS). Every register updates once per CLK edge. Stall freezes sequential progress, and higher-priority events override it.

## Interface
- WIDTH, 32, address width in bits
- RESET_VECTOR, 0, currPC value after reset
- EXC_VECTOR, 32'h0000_0080, exception handler address
- INC, 4, sequential increment
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- stall  in  1  hold fetch, low-priority events only
- exc_valid  in  1  take exception this cycle
- exc_pc  in  WIDTH  faulting address to save in epc
- eret_valid  in  1  return from exception
- redirect_valid  in  1  branch/jump resolved in execute
- redirect_pc  in  WIDTH  redirect target
- call_valid  in  1  fetch predicts a call
- call_target  in  WIDTH  call destination
- ret_valid  in  1  fetch predicts a return
- currPC  out  WIDTH  current fetch address
- epc  out  WIDTH  saved exception PC
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

## Operation
- Next-PC priority, highest first: exc_valid → EXC_VECTOR, and epc ← exc_pc. eret_valid → epc. redirect_valid → redirect_pc. Then, only when stall=0: call/ret handling, else currPC+INC. When stall=1 and no higher event is asserted, currPC holds.
- exc, eret and redirect take effect regardless of stall. They flush the prediction, so call_valid and ret_valid are ignored in that cycle and the RAS is unchanged.
- Call (stall=0, ret_valid=0): currPC ← call_target. Push currPC+INC.
- Return (stall=0, call_valid=0): if ras_count>0, currPC ← top and pop. If ras_count=0, ret is ignored and currPC ← currPC+INC.
- Call and return together (stall=0):
  - If ras_count>0: currPC ← call_target, and the top entry is replaced with currPC+INC. ras_count is unchanged.
  - If ras_count=0: behaves as a plain call.
- RAS is circular, with a top pointer and a count.
  - Push when full: overwrites the oldest entry. The pointer wraps and ras_count stays at RAS_DEPTH.
  - Pop when empty: per the return rule above.
- Arithmetic: currPC+INC is modulo 2^WIDTH. All-ones-aligned addresses wrap to 0 with no flag.
- epc changes only on exc_valid. exc_valid together with eret_valid: the exception wins, and epc ← exc_pc.

## Timing
- Reset: asserting RST immediately forces the following, without waiting for a clock edge:
  - currPC=RESET_VECTOR
  - epc=0
  - ras_count=0
  - RAS pointer=0
  - RAS contents don't-care
- Reset mid-operation discards all pending events. The first edge after deassertion applies normal rules.
- Latency: every event sampled at edge N is visible on currPC, epc and ras_count after edge N. There is no combinational input-to-output path.
- No handshake. The inputs are single-cycle qualifiers, and a level held for k cycles acts k times (for example, k pushes).

## Test plan
- Reset then free-run: RESET_VECTOR=0. Release RST, run 3 edges → currPC 0→4→8→12. Assert RST asynchronously mid-cycle → currPC=0 before the next edge.
- Stall vs redirect: at currPC=0x10, stall=1 for 2 edges → 0x10 held. stall=1 with redirect_valid=1, redirect_pc=0x200 → currPC=0x200.
- Exception/eret: at currPC=0x40, exc_valid with exc_pc=0x3C → currPC=0x80, epc=0x3C. Later eret_valid → currPC=0x3C. exc and eret in the same cycle → exception taken.
- RAS call/return: at 0x100, call to 0x400 → currPC=0x400, ras_count=1. Return → currPC=0x104, ras_count=0. Return when empty → currPC=0x108.
- RAS overflow with RAS_DEPTH=4: 5 calls from 0x0,0x10,0x20,0x30,0x40 → ras_count=4. Four returns yield 0x44,0x34,0x24,0x14, and a fifth return goes sequential.
- Wrap and combined: currPC=0xFFFF_FFFC with no event → 0x0. With ras_count=1 (top=0x500), call+ret at 0x600 with target 0x700 → currPC=0x700, top=0x604, ras_count=1.
